// File: rtl/fifo_mrq_pkg.sv
// Shared constants and helpers for the multi-reader broadcast FIFO.
package fifo_mrq_pkg;

    localparam int FWFT_REG  = 0;  // registered read, data one cycle after pop
    localparam int FWFT_HEAD = 1;  // head word presented, pop acknowledges it

    // count holds 0..depth inclusive, so it needs one bit beyond the address
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit th_ok(input int depth, input int addr_w,
                                 input int afull_th, input int aempty_th);
        return (depth == (1 << addr_w)) && (afull_th >= 0) && (afull_th <= depth)
            && (aempty_th >= 0) && (aempty_th < depth);
    endfunction

endpackage

// File: rtl/fifo_mrq_if.sv
// Producer/consumer bundle of the broadcast FIFO; the FIFO sits on the slave side.
interface fifo_mrq_if
    import fifo_mrq_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 4,
    parameter int RD_NUM     = 4
);
    localparam int CW = cnt_w(1 << ADDR_WIDTH);

    logic                                 clear;
    logic                                 push;
    logic [DATA_WIDTH-1:0]                data_in;
    logic                                 full;
    logic                                 almost_full;
    logic                                 overflow;
    logic [RD_NUM-1:0]                    rd_active;
    logic [RD_NUM-1:0]                    pop;
    logic [RD_NUM-1:0][DATA_WIDTH-1:0]    data_out;
    logic [RD_NUM-1:0]                    valid;
    logic [RD_NUM-1:0]                    empty;
    logic [RD_NUM-1:0]                    almost_empty;
    logic [RD_NUM-1:0][CW-1:0]            count;
    logic [RD_NUM-1:0]                    underflow;

    modport master (
        output clear, push, data_in, rd_active, pop,
        input  full, almost_full, overflow, data_out, valid, empty,
               almost_empty, count, underflow
    );

    modport slave (
        input  clear, push, data_in, rd_active, pop,
        output full, almost_full, overflow, data_out, valid, empty,
               almost_empty, count, underflow
    );

endinterface

// File: rtl/fifo_mrq_rd_port.sv
// One reader of the broadcast FIFO: read pointer, occupancy, output/head register and flags.
module fifo_mrq_rd_port
    import fifo_mrq_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = FWFT_REG,
    parameter int AFULL_TH   = 14,
    parameter int AEMPTY_TH  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    active,
    input  logic                    pop,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_ptr_nxt,
    input  logic [DATA_WIDTH-1:0]   rd_word,
    output logic [ADDR_WIDTH-1:0]   rd_ptr,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    valid,
    output logic                    empty,
    output logic                    almost_empty,
    output logic [ADDR_WIDTH:0]     count,
    output logic                    underflow,
    output logic                    full_hit,
    output logic                    afull_hit
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    logic pop_ok, load, uflow;

    always_comb begin
        pop_ok = 1'b0;
        load   = 1'b0;
        uflow  = 1'b0;
        if (active && !clear) begin
            if (FWFT == FWFT_HEAD) begin
                // count includes the head word, so memory still has one behind it when count > 1
                pop_ok = pop && valid;
                load   = (!valid && count != '0) || (pop_ok && count > CW'(1));
                uflow  = pop && !valid;
            end else begin
                pop_ok = pop && count != '0;
                load   = pop_ok;
                uflow  = pop && count == '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= '0;
            count     <= '0;
            valid     <= 1'b0;
            data_out  <= '0;
            underflow <= 1'b0;
        end else if (clear) begin
            rd_ptr    <= '0;
            count     <= '0;
            valid     <= 1'b0;
            data_out  <= '0;
            underflow <= 1'b0;
        end else if (!active) begin
            // follow the writer so activation starts at the next written word
            rd_ptr <= wr_ptr_nxt;
            count  <= '0;
            valid  <= 1'b0;
        end else begin
            count <= count + CW'(wr_en) - CW'(pop_ok);
            if (load) begin
                rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
                data_out <= rd_word;
            end
            if (FWFT == FWFT_HEAD) valid <= load || (valid && !pop_ok);
            else                   valid <= load;
            underflow <= underflow | uflow;
        end
    end

    assign empty        = (count == '0);
    assign almost_empty = (count <= CW'(AEMPTY_TH));
    assign full_hit     = active && (count == CW'(DEPTH));
    assign afull_hit    = active && (count >= CW'(AFULL_TH));

endmodule

// File: rtl/fifo_mrq.sv
// Single-write, multi-read broadcast FIFO: shared write side and storage, one read port per consumer.
module fifo_mrq
    import fifo_mrq_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 4,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int RD_NUM     = 4,
    parameter int FWFT       = FWFT_REG,
    parameter int AFULL_TH   = RAM_DEPTH - 2,
    parameter int AEMPTY_TH  = 1
) (
    input  logic        clk,
    input  logic        rst,
    fifo_mrq_if.slave   bus
);
    localparam int CW = cnt_w(RAM_DEPTH);

    generate
        if (!th_ok(RAM_DEPTH, ADDR_WIDTH, AFULL_TH, AEMPTY_TH)) begin : g_bad_cfg
            $error("fifo_mrq: RAM_DEPTH/threshold parameters out of range");
        end
    endgenerate

    logic [DATA_WIDTH-1:0]              mem [RAM_DEPTH];
    logic [ADDR_WIDTH-1:0]              wr_ptr, wr_ptr_nxt;
    logic                               wr_en;
    logic [RD_NUM-1:0]                  full_hit, afull_hit;
    logic [RD_NUM-1:0][ADDR_WIDTH-1:0]  rd_ptr;
    logic [RD_NUM-1:0][DATA_WIDTH-1:0]  rd_dout;
    logic [RD_NUM-1:0][CW-1:0]          rd_cnt;
    logic [RD_NUM-1:0]                  rd_vld, rd_emp, rd_aemp, rd_unf;

    assign bus.full        = |full_hit;
    assign bus.almost_full = |afull_hit;
    assign wr_en           = bus.push && !bus.full && !bus.clear;
    assign wr_ptr_nxt      = wr_en ? wr_ptr + ADDR_WIDTH'(1) : wr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            bus.overflow <= 1'b0;
        end else if (bus.clear) begin
            wr_ptr   <= '0;
            bus.overflow <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            if (bus.push && bus.full) bus.overflow <= 1'b1;
        end
    end

    // storage carries no reset; pointers and counts decide what is live
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= bus.data_in;
    end

    for (genvar i = 0; i < RD_NUM; i++) begin : g_rd
        fifo_mrq_rd_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .FWFT       (FWFT),
            .AFULL_TH   (AFULL_TH),
            .AEMPTY_TH  (AEMPTY_TH)
        ) u_rd (
            .clk          (clk),
            .rst          (rst),
            .clear        (bus.clear),
            .active       (bus.rd_active[i]),
            .pop          (bus.pop[i]),
            .wr_en        (wr_en),
            .wr_ptr_nxt   (wr_ptr_nxt),
            .rd_word      (mem[rd_ptr[i]]),
            .rd_ptr       (rd_ptr[i]),
            .data_out     (rd_dout[i]),
            .valid        (rd_vld[i]),
            .empty        (rd_emp[i]),
            .almost_empty (rd_aemp[i]),
            .count        (rd_cnt[i]),
            .underflow    (rd_unf[i]),
            .full_hit     (full_hit[i]),
            .afull_hit    (afull_hit[i])
        );
    end

    assign bus.data_out     = rd_dout;
    assign bus.valid        = rd_vld;
    assign bus.empty        = rd_emp;
    assign bus.almost_empty = rd_aemp;
    assign bus.count        = rd_cnt;
    assign bus.underflow    = rd_unf;

endmodule

// File: tb/tb_fifo_mrq.sv
// Scoreboard bench: a registered-read instance with 4 readers and a first-word-fall-through instance.
module tb_fifo_mrq;
    import fifo_mrq_pkg::*;

    localparam int DW    = 64;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int RD    = 4;
    localparam int RD1   = 2;
    localparam logic [RD-1:0] ALL = '1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_mrq_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_NUM(RD))  bus0 ();
    fifo_mrq_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_NUM(RD1)) bus1 ();

    fifo_mrq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_NUM(RD),  .FWFT(FWFT_REG))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    fifo_mrq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_NUM(RD1), .FWFT(FWFT_HEAD))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] mq  [RD][$];   // words each reader still owes
    logic [DW-1:0] sbq [RD][$];   // words popped, awaiting valid on data_out
    logic [DW-1:0] sb1 [$];       // FWFT reader0 expected stream
    logic          m_ovf;
    logic [RD-1:0] m_unf;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_state0(input logic [RD-1:0] pacc);
        logic mfull, mafull;
        mfull  = 1'b0;
        mafull = 1'b0;
        for (int i = 0; i < RD; i++) begin
            if (bus0.rd_active[i] && mq[i].size() == DEPTH) mfull = 1'b1;
            if (bus0.rd_active[i] && mq[i].size() >= DEPTH - 2) mafull = 1'b1;
            chk($sformatf("count%0d", i), 64'(bus0.count[i]), 64'(mq[i].size()));
            chk($sformatf("empty%0d", i), 64'(bus0.empty[i]), 64'(mq[i].size() == 0));
            chk($sformatf("aempty%0d", i), 64'(bus0.almost_empty[i]), 64'(mq[i].size() <= 1));
            chk($sformatf("valid%0d", i), 64'(bus0.valid[i]), 64'(pacc[i]));
            if (bus0.valid[i]) begin
                if (sbq[i].size() == 0) chk($sformatf("spurious_valid%0d", i), 64'(bus0.valid[i]), 64'd0);
                else                    chk($sformatf("data%0d", i), bus0.data_out[i], sbq[i].pop_front());
            end
        end
        chk("full", 64'(bus0.full), 64'(mfull));
        chk("almost_full", 64'(bus0.almost_full), 64'(mafull));
        chk("overflow", 64'(bus0.overflow), 64'(m_ovf));
        chk("underflow", 64'(bus0.underflow), 64'(m_unf));
    endtask

    task automatic step0(input logic push, input logic [DW-1:0] d, input logic [RD-1:0] act,
                         input logic [RD-1:0] pop, input logic clr);
        logic mfull;
        logic [RD-1:0] pacc;
        bus0.push = push; bus0.data_in = d; bus0.rd_active = act; bus0.pop = pop; bus0.clear = clr;
        mfull = 1'b0;
        pacc  = '0;
        for (int i = 0; i < RD; i++)
            if (act[i] && mq[i].size() == DEPTH) mfull = 1'b1;
        if (clr) begin
            for (int i = 0; i < RD; i++) begin mq[i].delete(); sbq[i].delete(); end
            m_ovf = 1'b0;
            m_unf = '0;
        end else begin
            if (push && mfull) m_ovf = 1'b1;
            for (int i = 0; i < RD; i++) begin
                if (!act[i]) mq[i].delete();
                else begin
                    if (pop[i] && mq[i].size() > 0) begin
                        pacc[i] = 1'b1;
                        sbq[i].push_back(mq[i].pop_front());
                    end else if (pop[i]) m_unf[i] = 1'b1;
                    if (push && !mfull) mq[i].push_back(d);
                end
            end
        end
        @(posedge clk); #1;
        bus0.push = 1'b0; bus0.pop = '0; bus0.clear = 1'b0;
        check_state0(pacc);
    endtask

    task automatic step1(input logic push, input logic [DW-1:0] d, input logic pop);
        bus1.push = push; bus1.data_in = d; bus1.pop = {1'b0, pop};
        if (pop && bus1.valid[0]) begin
            if (sb1.size() == 0) chk("f_spurious_valid", 64'(bus1.valid[0]), 64'd0);
            else                 chk("f_data", bus1.data_out[0], sb1.pop_front());
        end
        if (push && !bus1.full) sb1.push_back(d);
        @(posedge clk); #1;
        bus1.push = 1'b0; bus1.pop = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_ovf = 1'b0; m_unf = '0;
        bus0.clear = 1'b0; bus0.push = 1'b0; bus0.data_in = '0; bus0.rd_active = ALL; bus0.pop = '0;
        bus1.clear = 1'b0; bus1.push = 1'b0; bus1.data_in = '0; bus1.rd_active = 2'b01; bus1.pop = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset values
        check_state0('0);
        for (int i = 0; i < RD; i++) chk($sformatf("rst_dout%0d", i), bus0.data_out[i], 64'd0);

        // fill to full, overflow on 17th push, then push+pop at full
        for (int k = 0; k < DEPTH; k++) step0(1'b1, 64'(k), ALL, '0, 1'b0);
        step0(1'b1, 64'h99, ALL, '0, 1'b0);
        step0(1'b1, 64'h100, ALL, ALL, 1'b0);
        step0(1'b0, '0, ALL, '0, 1'b1);

        // independent drain: reader0 takes all 8, reader1 only 3, then reader0 pops on empty
        for (int k = 0; k < 8; k++) step0(1'b1, 64'h100 + 64'(k), ALL, '0, 1'b0);
        for (int k = 0; k < 8; k++) step0(1'b0, '0, ALL, (k < 3) ? 4'b0011 : 4'b0001, 1'b0);
        step0(1'b0, '0, ALL, 4'b0001, 1'b0);
        step0(1'b0, '0, ALL, '0, 1'b1);

        // masking: reader2 limits full, then drops out and only sees 0x33 once back
        for (int k = 0; k < 12; k++) step0(1'b1, 64'h200 + 64'(k), ALL, '0, 1'b0);
        for (int k = 0; k < 4; k++)  step0(1'b1, 64'h210 + 64'(k), ALL, 4'b1011, 1'b0);
        for (int k = 0; k < 3; k++)  step0(1'b1, 64'h220 + 64'(k), 4'b1011, '0, 1'b0);
        step0(1'b0, '0, ALL, '0, 1'b0);
        step0(1'b1, 64'h33, ALL, '0, 1'b0);
        step0(1'b0, '0, ALL, 4'b0100, 1'b0);
        chk("mask_word", bus0.data_out[2], 64'h33);
        step0(1'b0, '0, ALL, '0, 1'b1);

        // steady push+pop at count 8 across pointer wrap
        for (int k = 0; k < 8; k++)  step0(1'b1, 64'h300 + 64'(k), ALL, '0, 1'b0);
        for (int k = 0; k < 40; k++) step0(1'b1, 64'h308 + 64'(k), ALL, ALL, 1'b0);

        // clear at count 9 while pushing
        step0(1'b1, 64'h400, ALL, '0, 1'b0);
        step0(1'b1, 64'h401, ALL, '0, 1'b1);

        // async reset in the middle of a pop
        for (int k = 0; k < 3; k++) step0(1'b1, 64'h500 + 64'(k), ALL, '0, 1'b0);
        bus0.pop = ALL;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < RD; i++) begin mq[i].delete(); sbq[i].delete(); end
        m_ovf = 1'b0; m_unf = '0;
        check_state0('0);
        for (int i = 0; i < RD; i++) chk($sformatf("rst_mid_dout%0d", i), bus0.data_out[i], 64'd0);
        bus0.pop = '0;
        @(posedge clk); #1 rst = 1'b0;

        // FWFT: single word appears one edge after the write
        step1(1'b1, 64'hA5, 1'b0);
        chk("f_valid_after_write", 64'(bus1.valid[0]), 64'd0);
        step1(1'b0, '0, 1'b0);
        chk("f_valid_head", 64'(bus1.valid[0]), 64'd1);
        chk("f_head_a5", bus1.data_out[0], 64'hA5);
        chk("f_count1", 64'(bus1.count[0]), 64'd1);
        step1(1'b0, '0, 1'b1);
        chk("f_valid_drop", 64'(bus1.valid[0]), 64'd0);
        chk("f_count0", 64'(bus1.count[0]), 64'd0);

        // FWFT: two words, pop held two cycles
        step1(1'b1, 64'h11, 1'b0);
        step1(1'b1, 64'h22, 1'b0);
        step1(1'b0, '0, 1'b0);
        chk("f_head_11", bus1.data_out[0], 64'h11);
        chk("f_count2", 64'(bus1.count[0]), 64'd2);
        step1(1'b0, '0, 1'b1);
        chk("f_valid_kept", 64'(bus1.valid[0]), 64'd1);
        chk("f_head_22", bus1.data_out[0], 64'h22);
        step1(1'b0, '0, 1'b1);
        chk("f_valid_end", 64'(bus1.valid[0]), 64'd0);
        chk("f_underflow_clean", 64'(bus1.underflow[0]), 64'd0);
        step1(1'b0, '0, 1'b1);
        chk("f_underflow_set", 64'(bus1.underflow[0]), 64'd1);

        // FWFT: back-to-back pops at one word per cycle
        for (int k = 0; k < 6; k++) step1(1'b1, 64'h600 + 64'(k), 1'b0);
        for (int k = 0; k < 6; k++) begin
            chk("f_b2b_valid", 64'(bus1.valid[0]), 64'd1);
            step1(1'b0, '0, 1'b1);
        end
        chk("f_b2b_done", 64'(bus1.valid[0]), 64'd0);
        chk("f_b2b_count", 64'(bus1.count[0]), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
